dram_cache_rob: RTL
===================

// Module: dram_cache_rob
// PURPOSE
//  Reorder buffer between the tag comparator/memory read-return path and the AXI R channel to the host.
//  Allocates a TID per read request in issue order and accepts read-hit data from the tag comparator and
//  read-miss data from memory, both in any order. Returns beats on R strictly in allocation order.
// PARAMETERS
//  DATA_WIDTH  512  R-channel data width (`AXI_DATA_WIDTH)
//  ID_WIDTH    4    AXI ID width (`AXI_ID_WIDTH)
//  TID_WIDTH   4    transaction tag width (`TID_WIDTH); DEPTH = 2**TID_WIDTH entries
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    reset: one clock; reset is synchronous and active-high
//  alloc_req_i  in   1                    upstream requests a TID for a new read
//  alloc_id_i   in   ID_WIDTH             AXI ARID of that read
//  alloc_gnt_o  out  1                    TID granted this cycle
//  alloc_tid_o  out  TID_WIDTH            granted TID (= tail pointer)
//  rob_wren_i   in   1                    read-hit write from tag comparator
//  rob_data_i   in   TID_WIDTH+DATA_WIDTH {tid, data}
//  rob_afull_o  out  1                    tag comparator must not write while high
//  mem_wren_i   in   1                    read-miss fill data from memory
//  mem_data_i   in   TID_WIDTH+DATA_WIDTH {tid, data}
//  rid_o        out  ID_WIDTH             host R channel ID
//  rdata_o      out  DATA_WIDTH           host R channel data
//  rresp_o      out  2                    always 2'b00 (OKAY)
//  rlast_o      out  1                    always 1 (single-beat)
//  rvalid_o     out  1                    host R valid
//  rready_i     in   1                    host R ready
//  err_o        out  1                    sticky protocol-error flag
// BEHAVIOUR
//  State: head, tail (TID_WIDTH, wrap mod DEPTH); count (TID_WIDTH+1, 0..DEPTH); per-entry alloc, done,
//   id, data; output slice regs. Reset: head=tail=count=0, all alloc/done=0, rvalid_o=0, rid_o=0,
//   rdata_o=0, err_o=0, rob_afull_o=1. rob_afull_o is a flop of rst: high during reset and 1 cycle after.
//  Alloc: alloc_gnt_o = alloc_req_i & (count!=DEPTH), combinational; alloc_tid_o = tail.
//   On grant: id[tail]<=alloc_id_i, alloc[tail]<=1, done[tail]<=0, tail++.
//  Write: either port sets done[tid]<=1, data[tid]<=data. Ports may fire together to distinct TIDs:
//   both captured. Same TID same cycle: rob port wins, err_o<=1. Write to entry with alloc=0 or
//   done=1: dropped, err_o<=1. err_o clears only on rst.
//  Drain: load = alloc[head] & done[head] & (!rvalid_o | rready_i). On load: rid_o<=id[head],
//   rdata_o<=data[head], rvalid_o<=1, alloc/done[head]<=0, head++. Else if rvalid_o & rready_i: rvalid_o<=0.
//  Output FSM: R_EMPTY (rvalid_o=0) -> R_FULL on load; R_FULL stays on load or !rready_i;
//   R_FULL -> R_EMPTY on rready_i & !load. rid_o/rdata_o stable while rvalid_o & !rready_i.
//  Latency: write in cycle c with head ready -> rvalid_o high in cycle c+2. Throughput 1 beat/cycle.
//  count: +1 on grant, -1 on load, unchanged if both. Grant and load may target same index when
//   count==DEPTH-... only after load frees it next cycle; a freed slot is grantable the cycle after load.
//  Full (count==DEPTH): alloc_gnt_o=0, writes still accepted. Empty: no load, rvalid_o falls after last beat.
//  Wrap: head/tail roll DEPTH-1 -> 0 with no bubble.
//  Reset mid-operation: all entries, pointers and output slice cleared next edge; in-flight beat discarded.
// TESTING
//  In order: alloc ids 3,5,7 -> tids 0,1,2; rob writes tid 0,1,2 -> R beats rid 3,5,7 with matching data.
//  Out of order: write tid2, tid1 (mem), then tid0 -> no rvalid until tid0; then rid 3,5,7 back-to-back.
//  Full/wrap (DEPTH=16): 16 grants, 17th req -> gnt=0; drain one beat -> gnt=1 next cycle, tid wraps 0.
//  Backpressure: rready_i=0 for 5 cycles with rvalid_o=1 -> rid/rdata stable, no loss, then drains in order.
//  Collision: rob+mem same cycle tids 4,6 -> both stored, err_o=0; both on tid 4 -> rob data output, err_o=1.
//  Reset mid-flight: rst=1 for 1 cycle with 3 pending -> rvalid_o=0, count=0, next grant tid=0, afull 2 cycles.

Source files
------------

// File: rtl/dram_cache_rob.sv
// Reorder buffer for read returns: TIDs are allocated in issue order, hit/miss data land in any
// order, and beats leave on the AXI R channel strictly in allocation order.
module dram_cache_rob #(
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 4,
    parameter int TID_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            alloc_req_i,
    input  logic [ID_WIDTH-1:0]             alloc_id_i,
    output logic                            alloc_gnt_o,
    output logic [TID_WIDTH-1:0]            alloc_tid_o,
    input  logic                            rob_wren_i,
    input  logic [TID_WIDTH+DATA_WIDTH-1:0] rob_data_i,
    output logic                            rob_afull_o,
    input  logic                            mem_wren_i,
    input  logic [TID_WIDTH+DATA_WIDTH-1:0] mem_data_i,
    output logic [ID_WIDTH-1:0]             rid_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic [1:0]                      rresp_o,
    output logic                            rlast_o,
    output logic                            rvalid_o,
    input  logic                            rready_i,
    output logic                            err_o
);

    localparam int                 DEPTH    = 1 << TID_WIDTH;
    localparam logic [TID_WIDTH:0] FULL_CNT = (TID_WIDTH+1)'(DEPTH);

    localparam logic [0:0] R_EMPTY = 1'b0;
    localparam logic [0:0] R_FULL  = 1'b1;

    // R channel handshake: a beat transfers on any cycle where rvalid_o & rready_i; while
    // rvalid_o is high and rready_i low, rid_o/rdata_o hold their value.

    logic [TID_WIDTH-1:0]  head_q, head_d, tail_q, tail_d;
    logic [TID_WIDTH:0]    count_q, count_d;
    logic [DEPTH-1:0]      alloc_q, alloc_d, done_q, done_d;
    logic [ID_WIDTH-1:0]   id_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [0:0]            state_q, state_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  afull_q;

    logic [TID_WIDTH-1:0]  rob_tid, mem_tid;
    logic [DATA_WIDTH-1:0] rob_payload, mem_payload;
    logic                  grant, load, same_tid, rob_ok, mem_ok;

    assign rob_tid     = rob_data_i[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
    assign mem_tid     = mem_data_i[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
    assign rob_payload = rob_data_i[DATA_WIDTH-1:0];
    assign mem_payload = mem_data_i[DATA_WIDTH-1:0];

    assign grant    = alloc_req_i && (count_q != FULL_CNT);
    assign same_tid = rob_wren_i && mem_wren_i && (rob_tid == mem_tid);
    // Only a pending (allocated, not yet filled) entry may be written; the rob port wins a tie.
    assign rob_ok   = rob_wren_i && alloc_q[rob_tid] && !done_q[rob_tid];
    assign mem_ok   = mem_wren_i && !same_tid && alloc_q[mem_tid] && !done_q[mem_tid];
    assign load     = alloc_q[head_q] && done_q[head_q] && ((state_q == R_EMPTY) || rready_i);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        alloc_d = alloc_q;
        done_d  = done_q;
        state_d = state_q;
        rid_d   = rid_q;
        rdata_d = rdata_q;
        err_d   = err_q || (rob_wren_i && !rob_ok) || (mem_wren_i && !mem_ok);

        if (grant) begin
            tail_d          = tail_q + TID_WIDTH'(1);
            alloc_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
        end
        if (rob_ok) done_d[rob_tid] = 1'b1;
        if (mem_ok) done_d[mem_tid] = 1'b1;
        if (load) begin
            head_d          = head_q + TID_WIDTH'(1);
            alloc_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            rid_d           = id_q[head_q];
            rdata_d         = data_q[head_q];
        end

        if (grant && !load)      count_d = count_q + (TID_WIDTH+1)'(1);
        else if (!grant && load) count_d = count_q - (TID_WIDTH+1)'(1);

        case (state_q)
            R_EMPTY: if (load) state_d = R_FULL;
            R_FULL:  if (!load && rready_i) state_d = R_EMPTY;
            default: state_d = R_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        afull_q <= rst;
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            state_q <= R_EMPTY;
            rid_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            alloc_q <= alloc_d;
            done_q  <= done_d;
            state_q <= state_d;
            rid_q   <= rid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Payload storage needs no reset: alloc/done gate every read of it.
    always_ff @(posedge clk) begin
        if (grant)  id_q[tail_q]    <= alloc_id_i;
        if (rob_ok) data_q[rob_tid] <= rob_payload;
        if (mem_ok) data_q[mem_tid] <= mem_payload;
    end

    assign alloc_gnt_o = grant;
    assign alloc_tid_o = tail_q;
    // Held off while reset is asserted and for the cycle that follows it.
    assign rob_afull_o = rst || afull_q;
    assign rid_o       = rid_q;
    assign rdata_o     = rdata_q;
    assign rresp_o     = 2'b00;
    assign rlast_o     = 1'b1;
    assign rvalid_o    = (state_q == R_FULL);
    assign err_o       = err_q;

endmodule
